// File: rtl/barreira_sequenciador.sv
// barreira_sequenciador
//
// Purpose:
//   Light-barrier LED sequencer. The raw objeto_perto line is brought into the
//   clk domain through a two-flop synchroniser and debounced by a small FSM
//   (LIVRE -> CONFIRMANDO -> OBSTRUIDO -> LIBERANDO -> LIVRE). Each completed
//   obstruction/release cycle bumps a passage counter and emits a one-cycle
//   pulse. With BARREIRA_ALARME_EN defined, an obstruction lasting
//   ALARME_CICLOS cycles moves the FSM to ALARME, where the LED blinks with a
//   half-period of PISCA_CICLOS cycles.
//
// Configuration macro:
//   BARREIRA_ALARME_EN - builds the ALARME state, obstruction timer and blink
//                        counter. Without it, alarme is tied to 0 and the LED
//                        stays on for the whole obstruction.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   objeto_perto   in   raw sensor (asynchronous), 1 = object present
//   limpar_cont    in   synchronous clear of contagem (wins over increment)
//   led            out  barrier LED
//   contagem       out  completed passages, wraps at 2^CONT_W
//   passagem_pulso out  one-cycle pulse per completed passage
//   alarme         out  prolonged-obstruction flag
//   estado         out  current FSM state code

module barreira_sequenciador #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int ALARME_CICLOS   = 100,
    parameter int PISCA_CICLOS    = 8,
    parameter int CONT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              objeto_perto,
    input  logic              limpar_cont,
    output logic              led,
    output logic [CONT_W-1:0] contagem,
    output logic              passagem_pulso,
    output logic              alarme,
    output logic [2:0]        estado
);

    typedef enum logic [2:0] {
        LIVRE       = 3'd0,
        CONFIRMANDO = 3'd1,
        OBSTRUIDO   = 3'd2,
        LIBERANDO   = 3'd3,
        ALARME      = 3'd4
    } estado_t;

    localparam int DEB_W = $clog2(DEBOUNCE_CICLOS + 1);

    logic              sync1_q, sync2_q;
    logic              s_obj;
    estado_t           estado_q, estado_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic              led_q, led_d;
    logic              pulso_q, pulso_d;
    logic [CONT_W-1:0] cont_q, cont_d;

`ifdef BARREIRA_ALARME_EN
    localparam int TMR_W = $clog2(ALARME_CICLOS + 1);
    localparam int PSC_W = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;

    logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;
    logic [PSC_W-1:0]  pisca_q, pisca_d;
    logic              alarme_q, alarme_d;
`endif

    assign s_obj = sync2_q;

    // Next-state decode. Every output register is loaded from here, so outputs
    // change on the same edge that the FSM enters a state.
    always_comb begin
        estado_d = estado_q;
        deb_d    = deb_q;
        led_d    = led_q;
        pulso_d  = 1'b0;
        cont_d   = cont_q;
`ifdef BARREIRA_ALARME_EN
        timer_d   = timer_q;
        pisca_d   = pisca_q;
        // The obstruction timer saturates so a long obstruction cannot wrap it
        // back below the alarm threshold.
        timer_inc = (timer_q == TMR_W'(ALARME_CICLOS)) ? timer_q : timer_q + 1'b1;
`endif

        case (estado_q)
            LIVRE: begin
                led_d = 1'b0;
                if (s_obj) begin
                    estado_d = CONFIRMANDO;
                    deb_d    = DEB_W'(1);
                end
            end

            CONFIRMANDO: begin
                led_d = 1'b0;
                if (!s_obj) begin
                    estado_d = LIVRE;
                end else if (deb_q == DEB_W'(DEBOUNCE_CICLOS)) begin
                    estado_d = OBSTRUIDO;
                    led_d    = 1'b1;
`ifdef BARREIRA_ALARME_EN
                    timer_d  = '0;
`endif
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end

            OBSTRUIDO: begin
                led_d = 1'b1;
`ifdef BARREIRA_ALARME_EN
                timer_d = timer_inc;
                // The alarm threshold wins over a release seen on the same cycle.
                if (timer_inc == TMR_W'(ALARME_CICLOS)) begin
                    estado_d = ALARME;
                    pisca_d  = '0;
                end else if (!s_obj) begin
                    estado_d = LIBERANDO;
                    deb_d    = DEB_W'(1);
                end
`else
                if (!s_obj) begin
                    estado_d = LIBERANDO;
                    deb_d    = DEB_W'(1);
                end
`endif
            end

            LIBERANDO: begin
`ifdef BARREIRA_ALARME_EN
                // Timer keeps running and is not cleared on re-obstruction, so
                // a dropout after the alarm goes straight back to ALARME.
                timer_d = timer_inc;
`endif
                if (s_obj) begin
                    estado_d = OBSTRUIDO;
                    led_d    = 1'b1;
                end else if (deb_q == DEB_W'(DEBOUNCE_CICLOS)) begin
                    estado_d = LIVRE;
                    led_d    = 1'b0;
                    pulso_d  = 1'b1;
                    cont_d   = cont_q + 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end

`ifdef BARREIRA_ALARME_EN
            ALARME: begin
                if (!s_obj) begin
                    estado_d = LIBERANDO;
                    deb_d    = DEB_W'(1);
                end else if (pisca_q == PSC_W'(PISCA_CICLOS - 1)) begin
                    led_d   = ~led_q;
                    pisca_d = '0;
                end else begin
                    pisca_d = pisca_q + 1'b1;
                end
            end
`endif

            default: begin
                estado_d = LIVRE;
                led_d    = 1'b0;
            end
        endcase

        // Clear has priority over a simultaneous increment; the pulse still fires.
        if (limpar_cont) begin
            cont_d = '0;
        end

`ifdef BARREIRA_ALARME_EN
        alarme_d = (estado_d == ALARME);
`endif
    end

    // Synchroniser, FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            estado_q <= LIVRE;
            deb_q    <= '0;
            led_q    <= 1'b0;
            pulso_q  <= 1'b0;
            cont_q   <= '0;
`ifdef BARREIRA_ALARME_EN
            timer_q  <= '0;
            pisca_q  <= '0;
            alarme_q <= 1'b0;
`endif
        end else begin
            sync1_q  <= objeto_perto;
            sync2_q  <= sync1_q;
            estado_q <= estado_d;
            deb_q    <= deb_d;
            led_q    <= led_d;
            pulso_q  <= pulso_d;
            cont_q   <= cont_d;
`ifdef BARREIRA_ALARME_EN
            timer_q  <= timer_d;
            pisca_q  <= pisca_d;
            alarme_q <= alarme_d;
`endif
        end
    end

    assign led            = led_q;
    assign contagem       = cont_q;
    assign passagem_pulso = pulso_q;
    assign estado         = estado_q;
`ifdef BARREIRA_ALARME_EN
    assign alarme         = alarme_q;
`else
    assign alarme         = 1'b0;
`endif

endmodule
